// File: rtl/alu_req_sequencer.sv
// -----------------------------------------------------------------------------
// alu_req_sequencer
//
// Issue stage in front of a registered ALU that takes one cycle. Tagged requests
// arrive on a valid/ready interface and wait in a request FIFO. At most one
// operation is issued per cycle. Each result is captured the cycle after its
// issue and handed back, with its tag, on a valid/ready response interface.
// Issue is credit-gated, so every result already in the ALU pipe has a
// response slot reserved for it.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready   request handshake; req_ready = request FIFO not full
//   req_a, req_b            operands
//   req_op                  opcode 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA
//   req_tag                 request id, returned unchanged with the response
//   alu_a, alu_b            registered operands to the ALU
//   alu_opcode              registered opcode to the ALU
//   alu_enable              one-cycle issue strobe
//   alu_result              ALU result, valid the cycle after alu_enable
//   alu_overflow            ALU overflow, same timing as alu_result
//   rsp_valid / rsp_ready   response handshake; rsp_valid = buffer not empty
//   rsp_result              result
//   rsp_zero                rsp_result == 0
//   rsp_overflow            alu_overflow for ADD/SUB, 0 for other ops
//   rsp_err                 opcode was above 7
//   rsp_tag                 tag of the request
//   busy                    request FIFO, ALU pipe or response buffer occupied
// -----------------------------------------------------------------------------
module alu_req_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [3:0]            req_op,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_opcode,
    output logic                  alu_enable,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_overflow,
    output logic                  rsp_err,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  busy
);

    localparam int REQ_AW = $clog2(REQ_DEPTH);
    localparam int REQ_CW = REQ_AW + 1;
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int RSP_CW = RSP_AW + 1;
    localparam int OCC_W  = RSP_CW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [3:0]            op;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  overflow;
        logic                  err;
        logic [TAG_WIDTH-1:0]  tag;
    } rsp_t;

    // ---------------------------------------------------------------- storage
    req_t              req_mem [REQ_DEPTH];
    logic [REQ_AW-1:0] req_wr_ptr_q, req_rd_ptr_q;
    logic [REQ_CW-1:0] req_count_q, req_count_d;

    rsp_t              rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0] rsp_wr_ptr_q, rsp_rd_ptr_q;
    logic [RSP_CW-1:0] rsp_count_q, rsp_count_d;

    // ALU pipe tracking: stage 1 is the op currently in the ALU (alu_enable_q),
    // stage 2 is the op whose result is on alu_result this cycle.
    logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
    logic [3:0]            alu_opcode_q;
    logic                  alu_enable_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q, s2_tag_q;
    logic                  s1_addsub_q, s2_addsub_q;
    logic                  s1_err_q, s2_err_q;
    logic                  s2_vld_q;

    // ------------------------------------------------------------- handshakes
    logic       req_full, req_empty, req_push;
    logic       rsp_pop;
    logic       credit_ok, issue;
    logic [OCC_W-1:0] occ;
    req_t       req_head;
    rsp_t       rsp_head;

    assign req_full  = (req_count_q == REQ_CW'(REQ_DEPTH));
    assign req_empty = (req_count_q == '0);
    assign req_ready = !req_full;
    assign req_push  = req_valid && req_ready;
    assign req_head  = req_mem[req_rd_ptr_q];

    assign rsp_valid = (rsp_count_q != '0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem[rsp_rd_ptr_q];

    // Slots already promised: buffered responses plus both ALU stages. A pop
    // this cycle frees one. A new issue needs one more slot, so the
    // promised total must stay strictly below the depth.
    assign occ       = OCC_W'(rsp_count_q) + OCC_W'(alu_enable_q)
                     + OCC_W'(s2_vld_q) - OCC_W'(rsp_pop);
    assign credit_ok = (occ < OCC_W'(RSP_DEPTH));
    assign issue     = !req_empty && credit_ok;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_count_d = req_count_q;
        if (req_push && !issue) begin
            req_count_d = req_count_q + REQ_CW'(1);
        end else if (!req_push && issue) begin
            req_count_d = req_count_q - REQ_CW'(1);
        end

        rsp_count_d = rsp_count_q;
        if (s2_vld_q && !rsp_pop) begin
            rsp_count_d = rsp_count_q + RSP_CW'(1);
        end else if (!s2_vld_q && rsp_pop) begin
            rsp_count_d = rsp_count_q - RSP_CW'(1);
        end
    end

    // --------------------------------------------------------- control state
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_ptr_q <= '0;
            req_rd_ptr_q <= '0;
            req_count_q  <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_count_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_enable_q <= 1'b0;
            s1_tag_q     <= '0;
            s1_addsub_q  <= 1'b0;
            s1_err_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_tag_q     <= '0;
            s2_addsub_q  <= 1'b0;
            s2_err_q     <= 1'b0;
        end else begin
            req_count_q <= req_count_d;
            rsp_count_q <= rsp_count_d;
            if (req_push) req_wr_ptr_q <= req_wr_ptr_q + REQ_AW'(1);
            if (issue)    req_rd_ptr_q <= req_rd_ptr_q + REQ_AW'(1);
            if (s2_vld_q) rsp_wr_ptr_q <= rsp_wr_ptr_q + RSP_AW'(1);
            if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + RSP_AW'(1);

            // Operands hold their last values when nothing is issued.
            alu_enable_q <= issue;
            if (issue) begin
                alu_a_q      <= req_head.a;
                alu_b_q      <= req_head.b;
                alu_opcode_q <= req_head.op;
                s1_tag_q     <= req_head.tag;
                s1_addsub_q  <= (req_head.op == 4'd0) || (req_head.op == 4'd1);
                s1_err_q     <= req_head.op[3];
            end

            s2_vld_q    <= alu_enable_q;
            s2_tag_q    <= s1_tag_q;
            s2_addsub_q <= s1_addsub_q;
            s2_err_q    <= s1_err_q;
        end
    end

    // ---------------------------------------------------------- data storage
    // NOTE: the FIFO arrays are not reset; the counts and pointers alone say
    // which entries are live, and outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (req_push) begin
            req_mem[req_wr_ptr_q] <= '{a: req_a, b: req_b, op: req_op, tag: req_tag};
        end
        if (s2_vld_q) begin
            rsp_mem[rsp_wr_ptr_q] <= '{result:   alu_result,
                                       zero:     (alu_result == '0),
                                       overflow: s2_addsub_q && alu_overflow,
                                       err:      s2_err_q,
                                       tag:      s2_tag_q};
        end
    end

    // --------------------------------------------------------------- outputs
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_opcode_q;
    assign alu_enable = alu_enable_q;

    always_comb begin
        rsp_result   = '0;
        rsp_zero     = 1'b0;
        rsp_overflow = 1'b0;
        rsp_err      = 1'b0;
        rsp_tag      = '0;
        if (rsp_valid) begin
            rsp_result   = rsp_head.result;
            rsp_zero     = rsp_head.zero;
            rsp_overflow = rsp_head.overflow;
            rsp_err      = rsp_head.err;
            rsp_tag      = rsp_head.tag;
        end
    end

    assign busy = !req_empty || alu_enable_q || s2_vld_q || rsp_valid;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_req_sequencer
//
// Self-checking bench for alu_req_sequencer. A registered one-cycle ALU model
// answers the issue strobe. Its output is garbage on cycles with no issue, and
// its overflow is random for non-ADD/SUB ops. Every accepted request pushes
// its expected response, computed from the opcode rules, onto a queue. Every
// cycle with rsp_valid is compared against the head of that queue.
// The response buffer is four entries deep. Sustained one op per cycle needs
// room for the buffered response plus the two ops in the ALU pipe.
// -----------------------------------------------------------------------------
module tb_alu_req_sequencer;

    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int REQ = 4;
    localparam int RSP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0, req_b = '0;
    logic [3:0]    req_op = '0;
    logic [TW-1:0] req_tag = '0;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_opcode;
    logic          alu_enable;
    logic [DW-1:0] alu_result = '0;
    logic          alu_overflow = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero, rsp_overflow, rsp_err;
    logic [TW-1:0] rsp_tag;
    logic          busy;

    alu_req_sequencer #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .REQ_DEPTH(REQ), .RSP_DEPTH(RSP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference rules
    function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [3:0] op);
        logic [DW-1:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic ovf_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [3:0] op);
        logic [DW-1:0] r;
        r = alu_fn(a, b, op);
        if (op == 4'd0) return (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
        if (op == 4'd1) return (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
        return 1'b0;
    endfunction

    // Registered ALU model: result one cycle after alu_enable, noise otherwise.
    always @(posedge clk) begin
        if (alu_enable) begin
            alu_result   <= alu_fn(alu_a, alu_b, alu_opcode);
            alu_overflow <= (alu_opcode <= 4'd1) ? ovf_fn(alu_a, alu_b, alu_opcode)
                                                 : 1'($urandom);
        end else begin
            alu_result   <= $urandom;
            alu_overflow <= 1'($urandom);
        end
    end

    typedef struct packed {
        logic [DW-1:0] result;
        logic          zero;
        logic          ovf;
        logic          err;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepts = 0;
    int issues = 0;
    int pops = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: score the response and request handshakes that fire at the
    // coming edge, then advance to just after that edge.
    task automatic cycle();
        exp_t e;
        if (rsp_valid) begin
            check("rsp_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("rsp_result", rsp_result, e.result);
                check("rsp_zero", rsp_zero, e.zero);
                check("rsp_overflow", rsp_overflow, e.ovf);
                check("rsp_err", rsp_err, e.err);
                check("rsp_tag", rsp_tag, e.tag);
                if (rsp_ready) begin
                    e = exp_q.pop_front();
                    if (pops == 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    pops++;
                end
            end
        end
        if (req_valid && req_ready) begin
            e.result = alu_fn(req_a, req_b, req_op);
            e.zero   = (e.result == '0);
            e.ovf    = ovf_fn(req_a, req_b, req_op);
            e.err    = (req_op > 4'd7);
            e.tag    = req_tag;
            exp_q.push_back(e);
            accepts++;
        end
        if (alu_enable) issues++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] op, input logic [TW-1:0] tag);
        int a0;
        int n;
        a0 = accepts;
        n = 0;
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        while (accepts == a0 && n < 50) begin
            cycle();
            n++;
        end
        req_valid = 1'b0;
        check("send_accepted", accepts - a0, 1);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_busy", busy, 1'b0);
    endtask

    task automatic rand_req();
        req_a   = $urandom;
        req_b   = ($urandom_range(0, 7) == 0) ? req_a : DW'($urandom);
        req_op  = 4'($urandom_range(0, 9));
        req_tag = TW'($urandom);
    endtask

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            rand_req();
            req_valid = ($urandom_range(0, 9) < 6);
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        req_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
        check({pfx, "_alu_enable"}, alu_enable, 1'b0);
        check({pfx, "_req_ready"}, req_ready, 1'b1);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_alu_a"}, alu_a, '0);
        check({pfx, "_alu_opcode"}, alu_opcode, '0);
        check({pfx, "_rsp_result"}, rsp_result, '0);
        check({pfx, "_rsp_tag"}, rsp_tag, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 20000", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        int stale;

        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        cycle();

        // Single ADD: issue strobe one cycle, response three edges after accept.
        rsp_ready = 1'b1;
        req_a = 7; req_b = 5; req_op = 4'd0; req_tag = 4'd3; req_valid = 1'b1;
        check("t2_req_ready", req_ready, 1'b1);
        cycle();
        req_valid = 1'b0;
        check("t2_en_after_e0", alu_enable, 1'b0);
        cycle();
        check("t2_en_after_e1", alu_enable, 1'b1);
        check("t2_alu_a", alu_a, 7);
        check("t2_alu_b", alu_b, 5);
        check("t2_alu_op", alu_opcode, 0);
        cycle();
        check("t2_en_after_e2", alu_enable, 1'b0);
        check("t2_rsp_early", rsp_valid, 1'b0);
        cycle();
        check("t2_rsp_after_e3", rsp_valid, 1'b1);
        check("t2_result", rsp_result, 12);
        check("t2_zero", rsp_zero, 1'b0);
        check("t2_ovf", rsp_overflow, 1'b0);
        check("t2_tag", rsp_tag, 3);
        drain(20);

        // Overflow and zero flags; XOR must not inherit the ALU overflow.
        send(32'h7FFF_FFFF, 32'h1, 4'd0, 4'd1);
        send(32'd9, 32'd9, 4'd1, 4'd2);
        send(32'h8000_0000, 32'h8000_0000, 4'd4, 4'd4);
        drain(30);

        // Back-to-back: 8 ops, rsp_ready held high.
        pops = 0;
        accepts = 0;
        rsp_ready = 1'b1;
        n = 0;
        while (accepts < 8 && n < 20) begin
            rand_req();
            req_op = 4'($urandom_range(0, 7));
            req_valid = 1'b1;
            cycle();
            n++;
        end
        req_valid = 1'b0;
        check("t4_accept_cycles", n, 8);
        drain(40);
        check("t4_pops", pops, 8);
        check("t4_pop_span", last_pop_cyc - first_pop_cyc, 7);

        // Backpressure: issue stops at RSP credits, FIFO fills REQ more.
        rsp_ready = 1'b0;
        accepts = 0;
        issues = 0;
        n = 0;
        while (accepts < 8 && n < 20) begin
            rand_req();
            req_valid = 1'b1;
            cycle();
            n++;
        end
        req_valid = 1'b0;
        repeat (4) cycle();
        check("t5_accepts", accepts, RSP + REQ);
        check("t5_issues", issues, RSP);
        check("t5_req_ready", req_ready, 1'b0);
        check("t5_rsp_valid", rsp_valid, 1'b1);
        pops = 0;
        drain(60);
        check("t5_pops", pops, 8);

        // Illegal opcode, then a normal ADD.
        send(32'h1234, 32'h5678, 4'hB, 4'd9);
        send(32'd100, 32'd23, 4'd0, 4'd5);
        drain(30);

        // Random traffic, reset mid-stream, then random traffic to the end.
        rand_traffic(200);
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        #1;
        check_idle_outputs("t1_async");
        @(posedge clk);
        #1;
        cyc++;
        check_idle_outputs("t1_next");
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid || alu_enable) stale++;
            cycle();
        end
        check("t1_no_stale", stale, 0);

        rand_traffic(300);
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
